// File: rtl/risc_pkg.sv
// Shared register-file constants and dump FSM encoding for the risc_cpu core.
package risc_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    typedef enum logic [1:0] {
        DUMP_IDLE   = 2'd0,
        DUMP_STREAM = 2'd1,
        DUMP_DONE   = 2'd2
    } dump_state_t;

endpackage

// File: rtl/risc_regfile_rdport.sv
// One combinational register-file read port: range check, r0 masking, write-through bypass.
// Zero latency; no backpressure.
module risc_regfile_rdport #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ZERO_R0  = 1,
    parameter int ADDR_W   = 5
) (
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

    logic rd_ok;
    logic wr_hit;

    assign rd_ok  = ({1'b0, raddr} < NREGS) && !((ZERO_R0 != 0) && (raddr == '0));
    // A hit on a readable address implies the write itself is accepted.
    assign wr_hit = we && (waddr == raddr);

    always_comb begin
        rdata = '0;
        if (rd_ok) begin
            rdata = wr_hit ? wdata : regs[raddr];
        end
    end

endmodule

// File: rtl/risc_regfile_dump.sv
// Register file with NUM_RD bypassed read ports, one write port and a streaming dump engine.
// Reads zero latency; dump element held stable while dump_ready=0, one element/cycle when ready.
module risc_regfile_dump
    import risc_pkg::*;
#(
    parameter int   DATA_W   = DEF_DATA_W,
    parameter int   NUM_REGS = DEF_NUM_REGS,
    parameter int   NUM_RD   = 2,
    parameter int   ZERO_R0  = 1,
    localparam int  ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     dump_start,
    output logic                     dump_busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done
);

    localparam logic [ADDR_W:0]   NREGS    = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;
    dump_state_t       state;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;

    assign wr_ok = we && ({1'b0, waddr} < NREGS) && !((ZERO_R0 != 0) && (waddr == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        risc_regfile_rdport #(
            .DATA_W  (DATA_W),
            .NUM_REGS(NUM_REGS),
            .ZERO_R0 (ZERO_R0),
            .ADDR_W  (ADDR_W)
        ) u_rd (
            .regs (regs),
            .we   (we),
            .waddr(waddr),
            .wdata(wdata),
            .raddr(raddr[k*ADDR_W +: ADDR_W]),
            .rdata(rdata[k*DATA_W +: DATA_W])
        );
    end

    // Capture port looks one element ahead: element 0 from IDLE, idx+1 while streaming.
    assign cap_addr = (state == DUMP_STREAM) ? dump_addr + 1'b1 : '0;

    risc_regfile_rdport #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ZERO_R0 (ZERO_R0),
        .ADDR_W  (ADDR_W)
    ) u_cap (
        .regs (regs),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(cap_addr),
        .rdata(cap_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= DUMP_IDLE;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            case (state)
                DUMP_IDLE: begin
                    if (dump_start) begin
                        state      <= DUMP_STREAM;
                        dump_busy  <= 1'b1;
                        dump_valid <= 1'b1;
                        dump_addr  <= '0;
                        dump_data  <= cap_data;
                    end
                end
                DUMP_STREAM: begin
                    // Stalled elements are never re-sampled, so later writes don't leak in.
                    if (dump_ready) begin
                        if (dump_addr == LAST_IDX) begin
                            state      <= DUMP_DONE;
                            dump_valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_addr <= dump_addr + 1'b1;
                            dump_data <= cap_data;
                        end
                    end
                end
                DUMP_DONE: begin
                    state     <= DUMP_IDLE;
                    dump_busy <= 1'b0;
                    dump_done <= 1'b0;
                    dump_addr <= '0;
                end
                default: begin
                    state      <= DUMP_IDLE;
                    dump_busy  <= 1'b0;
                    dump_valid <= 1'b0;
                    dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_regfile_dump.sv
// Bench for risc_regfile_dump: default instance checked against a behavioural model every cycle,
// plus directed literal checks and a small reparametrised instance.
module tb_risc_regfile_dump;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic        dump_start = 1'b0;
    logic        dump_busy;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_done;

    logic        p_we = 1'b0;
    logic [2:0]  p_waddr = '0;
    logic [15:0] p_wdata = '0;
    logic [8:0]  p_raddr = '0;
    logic [47:0] p_rdata;
    logic        p_start = 1'b0;
    logic        p_busy;
    logic        p_valid;
    logic        p_ready = 1'b0;
    logic [2:0]  p_addr;
    logic [15:0] p_data;
    logic        p_done;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    risc_regfile_dump u_dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_done(dump_done)
    );

    risc_regfile_dump #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .ZERO_R0(0)) u_p (
        .clk(clk), .reset(reset), .we(p_we), .waddr(p_waddr), .wdata(p_wdata),
        .raddr(p_raddr), .rdata(p_rdata), .dump_start(p_start), .dump_busy(p_busy),
        .dump_valid(p_valid), .dump_ready(p_ready), .dump_addr(p_addr),
        .dump_data(p_data), .dump_done(p_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model of the default instance (32 x 32, r0 hardwired to zero).
    logic [31:0] m_regs [NR];
    int          m_phase = 0;   // 0 idle, 1 streaming, 2 done pulse
    int          m_idx = 0;
    logic [31:0] m_val = '0;

    function automatic logic [31:0] mread(input int a);
        if (a >= NR || a == 0) return 32'h0;
        if (we && int'(waddr) == a) return wdata;
        return m_regs[a];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_phase = 0;
            m_idx   = 0;
            m_val   = '0;
        end else begin
            if (m_phase == 0) begin
                if (dump_start) begin
                    m_phase = 1;
                    m_idx   = 0;
                    m_val   = mread(0);
                end
            end else if (m_phase == 1) begin
                if (dump_ready) begin
                    if (m_idx == NR - 1) m_phase = 2;
                    else begin
                        m_idx = m_idx + 1;
                        m_val = mread(m_idx);
                    end
                end
            end else begin
                m_phase = 0;
            end
            if (we && waddr != 5'd0) m_regs[waddr] = wdata;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_valid", dump_valid, 0);
            chk("rst_busy", dump_busy, 0);
            chk("rst_done", dump_done, 0);
            chk("rst_addr", dump_addr, 0);
            chk("rst_data", dump_data, 0);
        end else begin
            for (int k = 0; k < 2; k++)
                chk("model_rdata", rdata[k*32 +: 32], mread(int'(raddr[k*5 +: 5])));
            chk("model_valid", dump_valid, m_phase == 1);
            chk("model_busy", dump_busy, m_phase != 0);
            chk("model_done", dump_done, m_phase == 2);
            if (m_phase == 1) begin
                chk("model_daddr", dump_addr, m_idx);
                chk("model_ddata", dump_data, m_val);
            end
        end
    end

    logic [4:0]  got_addr [64];
    logic [31:0] got_data [64];
    int g_n, g_first, g_done_c, g_ndone;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    // Start a dump and collect accepted elements; rnd toggles ready and writes the stalled register.
    task automatic run_dump(input int budget, input bit rnd);
        g_n = 0; g_first = 0; g_done_c = 0; g_ndone = 0;
        dump_start = 1'b1;
        dump_ready = rnd ? 1'($urandom % 2) : 1'b1;
        tick();
        dump_start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (dump_valid && dump_ready && g_n < 64) begin
                got_addr[g_n] = dump_addr;
                got_data[g_n] = dump_data;
                if (g_n == 0) g_first = c;
                g_n++;
            end
            if (dump_done) begin
                g_ndone++;
                g_done_c = c;
            end
            if (g_ndone != 0 && c == g_done_c + 1) begin
                chk("busy_after_done", dump_busy, 0);
                break;
            end
            tick();
            if (rnd) begin
                dump_ready = 1'($urandom % 2);
                we    = dump_valid && !dump_ready;
                waddr = dump_addr;
                wdata = 32'hFFFF_FFFF;
            end
        end
        we = 1'b0;
        if (g_ndone == 0) begin
            n_total++;
            $display("FAIL dump_timeout: no dump_done within %0d cycles", budget);
        end
    endtask

    initial begin
        int hit;
        repeat (3) tick();
        chk("reset_rdata", rdata, 64'h0);
        reset = 1'b1;
        tick();

        // r0 masking and basic write/read
        wr(5'd0, 32'hDEAD_BEEF);
        wr(5'd5, 32'h1234_5678);
        raddr = {5'd5, 5'd0};
        #1;
        chk("r0_masked", rdata[31:0], 32'h0);
        chk("r5_read", rdata[63:32], 32'h1234_5678);
        for (int a = 1; a < NR; a++) begin
            if (a != 5) begin
                raddr = {5'd5, 5'(a)};
                #1;
                chk("others_zero", rdata[31:0], 32'h0);
            end
        end

        // same-cycle write-through
        tick();
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr = {5'd5, 5'd7};
        #1;
        chk("bypass_pre_edge", rdata[31:0], 32'hA5A5_A5A5);
        tick();
        we = 1'b0;
        #1;
        chk("bypass_post_edge", rdata[31:0], 32'hA5A5_A5A5);

        // full dump with ready held high
        for (int i = 0; i < NR; i++) wr(5'(i), 32'(i * 3));
        run_dump(40, 1'b0);
        chk("full_count", g_n, 32);
        chk("full_first_cycle", g_first, 1);
        chk("full_done_cycle", g_done_c, 33);
        chk("full_done_pulses", g_ndone, 1);
        for (int i = 0; i < g_n; i++) begin
            chk("full_addr", got_addr[i], i);
            chk("full_data", got_data[i], i * 3);
        end

        // backpressure with writes to the presented register while stalled
        tick();
        run_dump(400, 1'b1);
        chk("bp_count", g_n, 32);
        chk("bp_done_pulses", g_ndone, 1);
        for (int i = 0; i < g_n; i++) begin
            chk("bp_addr", got_addr[i], i);
            chk("bp_data", got_data[i], i * 3);
        end

        // reset in the middle of a dump
        tick();
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        hit = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dump_valid && dump_addr == 5'd10) begin
                hit = 1;
                break;
            end
        end
        chk("mid_reached_10", hit, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_valid", dump_valid, 0);
        chk("mid_busy", dump_busy, 0);
        chk("mid_done", dump_done, 0);
        for (int a = 0; a < NR; a++) begin
            raddr = {5'(a), 5'(a)};
            #1;
            chk("mid_regs_zero", rdata, 64'h0);
        end
        tick();
        reset = 1'b1;
        tick();
        run_dump(40, 1'b0);
        chk("zero_dump_count", g_n, 32);
        chk("zero_dump_done", g_ndone, 1);
        for (int i = 0; i < g_n; i++) chk("zero_dump_data", got_data[i], 0);

        // 8 x 16, three read ports, r0 writable
        for (int i = 0; i < 8; i++) begin
            p_we = 1'b1; p_waddr = 3'(i); p_wdata = (i == 0) ? 16'h00FF : 16'(i * 16'h11);
            tick();
        end
        p_we = 1'b0;
        p_raddr = 9'h000;
        #1;
        for (int k = 0; k < 3; k++) chk("p_r0_read", p_rdata[k*16 +: 16], 16'h00FF);
        tick();
        p_ready = 1'b1;
        p_start = 1'b1;
        tick();
        p_start = 1'b0;
        g_n = 0; g_done_c = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (p_valid) begin
                chk("p_dump_addr", p_addr, g_n);
                chk("p_dump_data", p_data, (g_n == 0) ? 16'h00FF : 16'(g_n * 16'h11));
                g_n++;
            end
            if (p_done) g_done_c = c;
        end
        chk("p_dump_count", g_n, 8);
        chk("p_done_cycle", g_done_c, 9);
        tick();
        p_we = 1'b1; p_waddr = 3'd7; p_wdata = 16'hBEEF;
        tick();
        p_we = 1'b0;
        p_raddr = {3'd7, 3'd0, 3'd7};
        #1;
        chk("p_r7_port0", p_rdata[15:0], 16'hBEEF);
        chk("p_r0_port1", p_rdata[31:16], 16'h00FF);
        chk("p_r7_port2", p_rdata[47:32], 16'hBEEF);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
